// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide controller.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops).
package mdu_pkg;

    // MDOP encodings
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // default busy-window lengths
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    // ops that run the multiply-length busy window
    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    // ops that run the divide-length busy window
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // signed flavour of an arithmetic op
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// mdu_compute: combinational datapath producing the next {HI,LO}.
// Optional feature macro: MDU_MADD_EN (adds multiply-accumulate results).
// Signed divide is done on magnitudes so 0x80000000 / -1 needs no special
// case: the unsigned quotient 0x80000000 keeps its sign pattern.
module mdu_compute (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div0
);
    import mdu_pkg::*;

    logic        sgn;
    logic [63:0] ea, eb, prod;
    logic [31:0] ma, mb, mbz, uq, ur, q, r;

    // product, quotient/remainder and result select
    always_comb begin
        sgn  = is_signed_op(op);
        ea   = {{32{sgn & a[31]}}, a};
        eb   = {{32{sgn & b[31]}}, b};
        prod = ea * eb;

        ma   = (sgn && a[31]) ? -a : a;
        mb   = (sgn && b[31]) ? -b : b;
        div0 = (b == 32'd0);
        mbz  = div0 ? 32'd1 : mb;
        uq   = ma / mbz;
        ur   = ma % mbz;
        q    = (sgn && (a[31] ^ b[31])) ? -uq : uq;
        r    = (sgn && a[31]) ? -ur : ur;

        res = {hi, lo};
        case (op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV, MD_DIVU:   res = {r, q};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
            default:           res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer, HI/LO owner, D-stage stall.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accepted).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic [3:0]  MDOP,
    input  logic        start,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q, hi_q, lo_q;
    logic [3:0]    op_q;
    logic [63:0]   res;
    logic          div0;

    // result is formed from latched operands and the live HI/LO, which
    // cannot change while busy since mthi/mtlo are only taken in IDLE
    mdu_compute u_compute (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (hi_q),
        .lo   (lo_q),
        .res  (res),
        .div0 (div0)
    );

    // FSM, countdown, operand latches and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= MD_NONE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && is_mul_op(MDOP)) begin
                        state <= ST_MUL;
                        cnt   <= CW'(MUL_CYCLES);
                        a_q   <= Src1;
                        b_q   <= Src2;
                        op_q  <= MDOP;
                    end else if (start && is_div_op(MDOP)) begin
                        state <= ST_DIV;
                        cnt   <= CW'(DIV_CYCLES);
                        a_q   <= Src1;
                        b_q   <= Src2;
                        op_q  <= MDOP;
                    end else if (MDOP == MD_MTHI) begin
                        hi_q <= Src1;
                    end else if (MDOP == MD_MTLO) begin
                        lo_q <= Src1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        // a divide by zero burns its cycles but leaves HI/LO alone
                        if (!(state == ST_DIV && div0))
                            {hi_q, lo_q} <= res;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // outputs: busy straight from the state flop, stall combinational
    always_comb begin
        busy  = (state != ST_IDLE);
        stall = d_is_md & (busy | start);
        HI    = hi_q;
        LO    = lo_q;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed stimulus, cycle-level reference model, per-cycle compare.
// Build with or without MDU_MADD_EN; expectations follow the macro.
module tb_mdu_ctrl;
    localparam int MULN = 5;
    localparam int DIVN = 10;
`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Src1 = '0, Src2 = '0;
    logic [3:0]  MDOP = '0;
    logic        start = 1'b0, d_is_md = 1'b0;
    logic        busy, stall;
    logic [31:0] HI, LO;

    mdu_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset(reset), .Src1(Src1), .Src2(Src2), .MDOP(MDOP),
        .start(start), .d_is_md(d_is_md), .busy(busy), .stall(stall),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mul_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint sa = $signed(a);
        longint sb = $signed(b);
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        p = (op == 1 || op == 7 || op == 9) ? 64'(sa * sb) : ua * ub;
        if (op == 7 || op == 8) return acc + p;
        if (op == 9 || op == 10) return acc - p;
        return p;
    endfunction

    function automatic logic [63:0] div_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint sa = $signed(a);
        longint sb = $signed(b);
        logic [31:0] q, r;
        if (b == 0) return acc;
        if (op == 3) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic bit model_mulop(input logic [3:0] op);
        return (op == 1 || op == 2) || (MADD && op >= 7 && op <= 10);
    endfunction

    // cyc is the index of the cycle currently in progress; a start taken in
    // cycle t keeps the unit busy for t+1..t+N and lands at the end of t+N
    int          cyc = 0;
    int          busy_last = -1;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] p_res = '0;

    always @(posedge clk) begin
        int t;
        t = cyc;
        cyc = cyc + 1;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            busy_last = -1;
        end else if (t <= busy_last) begin
            if (t == busy_last) {m_hi, m_lo} = p_res;
        end else if (start && model_mulop(MDOP)) begin
            busy_last = t + MULN;
            p_res = mul_model(MDOP, Src1, Src2, {m_hi, m_lo});
        end else if (start && (MDOP == 3 || MDOP == 4)) begin
            busy_last = t + DIVN;
            p_res = div_model(MDOP, Src1, Src2, {m_hi, m_lo});
        end else if (MDOP == 5) begin
            m_hi = Src1;
        end else if (MDOP == 6) begin
            m_lo = Src1;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic eb;
            eb = (cyc <= busy_last);
            chk("busy", {31'b0, busy}, {31'b0, eb});
            chk("stall", {31'b0, stall}, {31'b0, d_is_md & (eb | start)});
            chk("HI", HI, m_hi);
            chk("LO", LO, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit st);
        MDOP = o; Src1 = a; Src2 = b; start = st;
        @(posedge clk); #1;
        MDOP = '0; start = 1'b0; Src1 = $urandom; Src2 = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        @(posedge clk); chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        reset = 1'b0;

        // mult -2 * 3
        op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        chk("mult busy c1", {31'b0, busy}, 32'd1);
        idle(5);
        chk("mult busy c6", {31'b0, busy}, 32'd0);
        chk("mult HI", HI, 32'hFFFFFFFF);
        chk("mult LO", LO, 32'hFFFFFFFA);

        // multu max * max
        op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        idle(5);
        chk("multu HI", HI, 32'hFFFFFFFE);
        chk("multu LO", LO, 32'h00000001);

        // div -7 / 2 with a dependent instruction waiting in D
        d_is_md = 1'b1;
        chk("div stall c0", {31'b0, stall}, 32'd0);
        op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        chk("div stall c1", {31'b0, stall}, 32'd1);
        idle(10);
        chk("div stall c11", {31'b0, stall}, 32'd0);
        chk("div LO", LO, 32'hFFFFFFFD);
        chk("div HI", HI, 32'hFFFFFFFF);
        d_is_md = 1'b0;

        // divu by zero after preload; mtlo while busy is dropped
        op(4'd5, 32'h11, 32'd0, 1'b0);
        op(4'd6, 32'h22, 32'd0, 1'b0);
        chk("mthi", HI, 32'h11);
        chk("mtlo", LO, 32'h22);
        op(4'd4, 32'd5, 32'd0, 1'b1);
        idle(2);
        op(4'd6, 32'h99, 32'd0, 1'b0);
        idle(7);
        chk("div0 busy", {31'b0, busy}, 32'd0);
        chk("div0 HI", HI, 32'h11);
        chk("div0 LO", LO, 32'h22);

        // overflow divide
        op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        idle(10);
        chk("ovf LO", LO, 32'h80000000);
        chk("ovf HI", HI, 32'h0);

        // reset mid-divide
        op(4'd3, 32'd100, 32'd7, 1'b1);
        idle(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        idle(10);
        chk("abort late LO", LO, 32'd0);
        op(4'd1, 32'd4, 32'd5, 1'b1);
        idle(5);
        chk("mult45 LO", LO, 32'd20);
        chk("mult45 HI", HI, 32'd0);

        // accumulate ops
        op(4'd5, 32'h0, 32'd0, 1'b0);
        op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        op(4'd8, 32'd1, 32'd1, 1'b1);
        chk("maddu busy", {31'b0, busy}, {31'b0, MADD});
        idle(5);
        chk("maddu HI", HI, MADD ? 32'd1 : 32'd0);
        chk("maddu LO", LO, MADD ? 32'd0 : 32'hFFFFFFFF);
        op(4'd9, 32'd1, 32'd1, 1'b1);
        idle(5);
        chk("msub HI", HI, 32'd0);
        chk("msub LO", LO, 32'hFFFFFFFF);

        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim still running at %0t, limit 100000", $time);
        $fatal(1, "timeout");
    end

endmodule
